// File: rtl/datapath_controller.sv
// Multi-cycle sequencer producing every control input of the register-file/ALU/RAM datapath.
// Optional conditional branch (op 100 = BZ) is built when DPCTRL_BRANCH_EN is defined.
module datapath_controller #(
    parameter int PC_WIDTH  = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          instr,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [3:0]           signalBits,
    output logic [4:0]           readA,
    output logic [4:0]           readB,
    output logic [4:0]           writeReg,
    output logic [4:0]           functionsel,
    output logic                 ALUcarry,
    output logic                 write,
    output logic                 RAMwrite,
    output logic                 muxSelect,
    output logic [PC_WIDTH-1:0]  pc,
    output logic                 halted,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH,
        EXEC,
        MEMRD,
        WB,
        HALT
    } stateT;

    localparam logic [2:0] opNop   = 3'b000;
    localparam logic [2:0] opAlu   = 3'b001;
    localparam logic [2:0] opLoad  = 3'b010;
    localparam logic [2:0] opStore = 3'b011;
    localparam logic [2:0] opBz    = 3'b100;
    localparam logic [2:0] opHalt  = 3'b101;

    stateT       state;
    logic [31:0] ir;

    logic [2:0] op;
    logic [4:0] fs;
    logic [4:0] da;
    logic [4:0] aa;
    logic [4:0] ba;
    logic       cin;

    assign op  = ir[31:29];
    assign fs  = ir[28:24];
    assign da  = ir[23:19];
    assign aa  = ir[18:14];
    assign ba  = ir[13:9];
    assign cin = ir[0];

    logic                branchTaken;
    logic                isIllegal;
    logic [PC_WIDTH-1:0] pcNext;

`ifdef DPCTRL_BRANCH_EN
    logic signed [31:0]  offWide;
    logic [PC_WIDTH-1:0] offExt;

    // The 9-bit offset is sign-extended and then cut to PC width so wrap-around is modular.
    assign offWide     = 32'(signed'(ir[8:0]));
    assign offExt      = offWide[PC_WIDTH-1:0];
    assign branchTaken = (op == opBz) && signalBits[0];
    assign isIllegal   = (op[2:1] == 2'b11);
    assign pcNext      = branchTaken ? (pc + offExt) : (pc + PC_WIDTH'(1));
`else
    logic unusedBranchInputs;

    assign unusedBranchInputs = ^{signalBits, ir[8:1]};
    assign branchTaken        = 1'b0;
    assign isIllegal          = (op[2:1] == 2'b11) || (op == opBz);
    assign pcNext             = pc + PC_WIDTH'(1);
`endif

    // State, instruction register, PC and the retire bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            ir      <= '0;
            pc      <= '0;
            retired <= '0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (op)
                        opLoad: state <= MEMRD;
                        opHalt: begin
                            state   <= HALT;
                            halted  <= 1'b1;
                            retired <= retired + CNT_WIDTH'(1);
                        end
                        default: begin
                            state   <= FETCH;
                            pc      <= pcNext;
                            retired <= retired + CNT_WIDTH'(1);
                            if (isIllegal) begin
                                illegal <= 1'b1;
                            end
                        end
                    endcase
                end
                MEMRD: state <= WB;
                WB: begin
                    state   <= FETCH;
                    pc      <= pc + PC_WIDTH'(1);
                    retired <= retired + CNT_WIDTH'(1);
                end
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

    // Datapath controls; address selects stay stable from EXEC through WB for loads.
    always_comb begin
        instr_ready = 1'b0;
        readA       = '0;
        readB       = '0;
        writeReg    = '0;
        functionsel = '0;
        ALUcarry    = 1'b0;
        write       = 1'b0;
        RAMwrite    = 1'b0;
        muxSelect   = 1'b0;
        case (state)
            FETCH: instr_ready = ~rst;
            EXEC: begin
                readA       = aa;
                readB       = ba;
                functionsel = fs;
                ALUcarry    = cin;
                if (op == opAlu) begin
                    write    = 1'b1;
                    writeReg = da;
                end
                if (op == opStore) begin
                    RAMwrite = 1'b1;
                end
            end
            MEMRD: begin
                readA       = aa;
                readB       = ba;
                functionsel = fs;
                ALUcarry    = cin;
            end
            WB: begin
                readA       = aa;
                readB       = ba;
                functionsel = fs;
                ALUcarry    = cin;
                write       = 1'b1;
                writeReg    = da;
                muxSelect   = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            write    = 1'b0;
            RAMwrite = 1'b0;
        end
    end

endmodule
